adder_sum_display: RTL and testbench

//   Downstream stage of the 5-bit adder. Accepts the adder's 6-bit sum through a

---
 rtl/adder_sum_display.sv | 124 ++++++++++++
 tb/tb_adder_sum_display.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_display.sv
// Takes the adder's 6-bit sum over valid/ready and converts it to two BCD digits.
// The conversion is a sequential double-dabble; the result drives a 2-digit multiplexed 7-segment display.
module adder_sum_display #(
  parameter int SCAN_DIV    = 50000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sum_in,
  input  logic       sum_valid,
  output logic       ready,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = SEG_ACT_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state;
  logic [13:0] scratch;
  logic [13:0] adj;
  logic [2:0]  bit_cnt;

  // Correct each BCD nibble before the shift so it carries properly into the next digit.
  always_comb begin
    adj = scratch;
    if (adj[13:10] >= 4'd5) adj[13:10] = adj[13:10] + 4'd3;
    if (adj[9:6]   >= 4'd5) adj[9:6]   = adj[9:6]   + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      scratch  <= '0;
      bit_cnt  <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (sum_valid) begin
          scratch <= {8'd0, sum_in};
          bit_cnt <= 3'd6;
          ready   <= 1'b0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          scratch <= {adj[12:0], 1'b0};
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd1) state <= S_DONE;
        end
        S_DONE: begin
          bcd_tens <= scratch[13:10];
          bcd_ones <= scratch[9:6];
          done     <= 1'b1;
          ready    <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'h3F;
      4'd1: dec7 = 7'h06;
      4'd2: dec7 = 7'h5B;
      4'd3: dec7 = 7'h4F;
      4'd4: dec7 = 7'h66;
      4'd5: dec7 = 7'h6D;
      4'd6: dec7 = 7'h7D;
      4'd7: dec7 = 7'h07;
      4'd8: dec7 = 7'h7F;
      4'd9: dec7 = 7'h6F;
      default: dec7 = 7'h00;
    endcase
  endfunction

  logic [CW-1:0] scan_cnt;
  logic          sel;
  logic [6:0]    seg_raw;
  logic [1:0]    an_raw;

  // The tens digit is blanked when it is zero, but its enable still asserts so the scan timing stays even.
  always_comb begin
    seg_raw = dec7(bcd_ones);
    an_raw  = 2'b01;
    if (sel) begin
      seg_raw = (bcd_tens == 4'd0) ? 7'h00 : dec7(bcd_tens);
      an_raw  = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
      seg      <= SEG_OFF;
      an       <= AN_OFF;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg <= seg_raw ^ {7{SEG_ACT_LOW}};
      an  <= an_raw  ^ {2{SEG_ACT_LOW}};
    end
  end

endmodule

// File: tb/tb_adder_sum_display.sv
// Bench for adder_sum_display: stimulus pushes expected BCD results into a queue.
// A monitor pops an entry and compares it on every done pulse; directed checks cover handshake timing, the display and reset.
module tb_adder_sum_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sum_in = '0;
  logic       sum_valid = 1'b0;
  logic       ready, done;
  logic [3:0] bcd_tens, bcd_ones;
  logic [6:0] seg;
  logic [1:0] an;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  adder_sum_display #(.SCAN_DIV(4), .SEG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid), .ready(ready),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_done: got tens=%0d ones=%0d with nothing expected", bcd_tens, bcd_ones);
        end else begin
          e = exp_q.pop_front();
          if ({bcd_tens, bcd_ones} !== e) begin
            errors++;
            $display("FAIL result: got tens=%0d ones=%0d, required tens=%0d ones=%0d",
                     bcd_tens, bcd_ones, e[7:4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [5:0] v, input logic [3:0] t, input logic [3:0] o, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin
      errors++; checks++;
      $display("FAIL ready_timeout: got ready=0, required 1 within 100 cycles");
    end
    sum_in = v; sum_valid = 1'b1;
    if (push) exp_q.push_back({t, o});
    @(posedge clk);
    #1 sum_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // tc/oc are active-high codes expected for the tens/ones digit; outputs are active-low.
  task automatic check_disp(input logic [6:0] tc, input logic [6:0] oc);
    logic [1:0] prev;
    int run = 1;
    int nchg = 0;
    @(negedge clk);
    prev = an;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (an == 2'b01)      chk("seg_tens", {9'd0, seg}, {9'd0, ~tc});
      else if (an == 2'b10) chk("seg_ones", {9'd0, seg}, {9'd0, ~oc});
      else                  chk("an_onehot", {14'd0, an}, 16'h0001);
      if (an === prev) run++;
      else begin
        if (nchg > 0) chk("scan_period", 16'(run), 16'd4);
        nchg++;
        run = 1;
        prev = an;
      end
    end
    chk("scan_toggles", 16'(nchg >= 3), 16'd1);
  endtask

  initial begin
    int acc;
    logic [5:0] v;

    // Reset state
    #12;
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_bcd",   {8'd0, bcd_tens, bcd_ones}, 16'd0);
    chk("rst_done",  {15'd0, done}, 16'd0);
    chk("rst_seg",   {9'd0, seg}, 16'h007F);
    chk("rst_an",    {14'd0, an}, 16'h0003);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 12 -> (1,2) with exact handshake timing
    send(6'd12, 4'd1, 4'd2, 1'b1);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t1_ready_c%0d", k), {15'd0, ready}, {15'd0, (k >= 7)});
      chk($sformatf("t1_done_c%0d", k),  {15'd0, done},  {15'd0, (k == 7)});
    end
    drain();

    // Boundary values, plus display checks for the blanked and two-digit cases
    send(6'd0, 4'd0, 4'd0, 1'b1);
    drain();
    check_disp(7'h00, 7'h3F);
    send(6'd9,  4'd0, 4'd9, 1'b1);
    send(6'd10, 4'd1, 4'd0, 1'b1);
    send(6'd62, 4'd6, 4'd2, 1'b1);
    drain();
    check_disp(7'h7D, 7'h5B);
    send(6'd63, 4'd6, 4'd3, 1'b1);
    drain();

    // valid pulsed mid-conversion is ignored
    send(6'd20, 4'd2, 4'd0, 1'b1);
    repeat (3) @(negedge clk);
    sum_in = 6'd45; sum_valid = 1'b1;
    @(posedge clk);
    #1 sum_valid = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Reset during conversion aborts it
    send(6'd30, 4'd0, 4'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_ready", {15'd0, ready}, 16'd1);
    chk("t5_bcd",   {8'd0, bcd_tens, bcd_ones}, 16'd0);
    chk("t5_seg",   {9'd0, seg}, 16'h007F);
    chk("t5_an",    {14'd0, an}, 16'h0003);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    send(6'd7, 4'd0, 4'd7, 1'b1);
    drain();

    // valid held high, data changing every cycle: one accept per 8 cycles
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      v = 6'(i * 5 + 3);
      sum_in = v; sum_valid = 1'b1;
      if (ready) begin
        exp_q.push_back({4'(v / 10), 4'(v % 10)});
        acc++;
      end
      @(negedge clk);
    end
    sum_valid = 1'b0;
    chk("t3_accepts", 16'(acc), 16'd3);
    drain();

    // Full sweep against s/10, s%10
    for (int s = 0; s < 64; s++) send(6'(s), 4'(s / 10), 4'(s % 10), 1'b1);
    drain();
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end
endmodule
